// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared instruction-word layout, opcodes and register codes.
package instruction_fetch_pkg;
  localparam int OPC_MSB = 27;
  localparam int OPC_LSB = 24;
  localparam int OPND_W = 24;
  localparam int TGT_MSB = 23;
  localparam int TGT_LSB = 16;
  localparam int REDIR_W = TGT_MSB - TGT_LSB + 1;
  localparam int FETCH_CNT_W = 16;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_STO = 4'd1,
    OP_ADD = 4'd2,
    OP_BLE = 4'd3,
    OP_JMP = 4'd4,
    OP_LED = 4'd5
  } opcode_e;
  localparam logic [7:0] REG_R0 = 8'd0;
  localparam logic [7:0] REG_R1 = 8'd1;
  localparam logic [7:0] REG_R2 = 8'd2;
  localparam logic [7:0] REG_R3 = 8'd3;
  function automatic opcode_e get_opcode(input logic [OPC_MSB:0] insn);
    return opcode_e'(insn[OPC_MSB:OPC_LSB]);
  endfunction
endpackage

// File: rtl/instruction_fetch_pc.sv
// fetch_pc: program counter with load, increment and hold; wraps silently.
module fetch_pc #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  always_comb pc_d = load_i ? load_val_i : inc_i ? pc_q + ADDR_W'(1) : pc_q;
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC + instruction register stage with stall, redirect squash
// and a saturating count of instructions accepted by decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'd0,
  parameter int INSN_W = 28
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [ADDR_W-1:0]      oAddress,
  input  logic [INSN_W-1:0]      iInstruction,
  output logic [INSN_W-1:0]      oInstruction,
  output logic [ADDR_W-1:0]      oInstrPC,
  output logic                   oValid,
  input  logic                   iReady,
  input  logic                   iRedirect,
  input  logic [REDIR_W-1:0]     iRedirectTarget,
  output logic [FETCH_CNT_W-1:0] oFetchCount
);
  typedef enum logic [1:0] {BUBBLE, RUN, FLUSH} state_e;
  state_e state_q, state_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [FETCH_CNT_W-1:0] cnt_q, cnt_d;
  logic xfer, load_slot, pc_inc;
  fetch_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk       (Clock),
    .rst       (Reset),
    .load_i    (iRedirect),
    .inc_i     (pc_inc),
    .load_val_i(ADDR_W'(iRedirectTarget)),
    .pc_o      (oAddress)
  );
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= BUBBLE;
      ir_q    <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end
  // a redirect squashes the slot even when it coincides with a transfer
  always_comb state_d = iRedirect ? FLUSH : load_slot ? RUN : state_q;
  always_comb begin
    oValid    = state_q == RUN;
    xfer      = oValid & iReady;
    load_slot = xfer | ~oValid;
    pc_inc    = load_slot & ~iRedirect;
  end
  always_comb begin
    ir_d  = pc_inc ? iInstruction : ir_q;
    ipc_d = pc_inc ? oAddress : ipc_q;
    cnt_d = (xfer && cnt_q != '1) ? cnt_q + FETCH_CNT_W'(1) : cnt_q;
  end
  assign oInstruction = ir_q;
  assign oInstrPC     = ipc_q;
  assign oFetchCount  = cnt_q;
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'd0, meaning the first address fetched after reset.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning the program-counter and ROM address width.
REQ-003 The block SHALL have parameter INSN_W, default 28, meaning the instruction width (4-bit opcode in [27:24], 24-bit operand field in [23:0]).
REQ-004 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port oAddress, output, ADDR_W bits: the current PC, driven straight to the combinational instruction ROM.
REQ-007 The block SHALL have port iInstruction, input, INSN_W bits: the ROM data for oAddress, valid in the same cycle.
REQ-008 The block SHALL have port oInstruction, output, INSN_W bits: the registered instruction presented to decode.
REQ-009 The block SHALL have port oInstrPC, output, ADDR_W bits: the address oInstruction was fetched from.
REQ-010 The block SHALL have port oValid, output, 1 bit: oInstruction is a real instruction, not a bubble.
REQ-011 The block SHALL have port iReady, input, 1 bit: decode accepts oInstruction this cycle.
REQ-012 The block SHALL have port iRedirect, input, 1 bit: a taken JMP or BLE from execute.
REQ-013 The block SHALL have port iRedirectTarget, input, 8 bits: the branch target (instruction bits [23:16]), zero-extended to ADDR_W.
REQ-014 The block SHALL have port oFetchCount, output, 16 bits: the count of accepted instructions, saturating.

Function
REQ-015 The block SHALL be a 3-state FSM: BUBBLE (oValid=0, IR empty), RUN (IR holds a valid instruction), and FLUSH (one-cycle squash after a redirect).
REQ-016 A transfer SHALL occur when oValid=1 and iReady=1; a load slot SHALL exist when there is a transfer or oValid=0.
REQ-017 In a load slot with no redirect, the block SHALL load IR <= iInstruction, oInstrPC <= oAddress, and PC <= PC+1, then enter RUN; latency from address to oInstruction is 1 cycle.
REQ-018 When oValid=1 and iReady=0, the block SHALL hold PC, IR, oInstrPC and oValid unchanged (stall).
REQ-019 When iRedirect=1, the block SHALL set PC <= zero-extended iRedirectTarget, clear oValid, and enter FLUSH, regardless of iReady or the current state.
REQ-020 In FLUSH, oValid SHALL be 0; the next cycle SHALL load from the new PC and enter RUN, unless iRedirect is asserted again, in which case the block re-enters FLUSH with the newest target.
REQ-021 A transfer in the same cycle as iRedirect SHALL still count as accepted: oFetchCount increments and the instruction is not re-presented.
REQ-022 PC SHALL wrap from all-ones to 0 without any flag.
REQ-023 oFetchCount SHALL increment by 1 per transfer and saturate at 16'hFFFF.
REQ-024 oAddress SHALL equal PC at all times (no combinational path from iRedirect to oAddress).

Reset
REQ-025 Reset (synchronous, active-high, priority over all other inputs) SHALL set PC=RESET_PC, state=BUBBLE, oValid=0, oInstruction=0, oInstrPC=0, and oFetchCount=0.
REQ-026 Reset asserted mid-stall or mid-FLUSH SHALL discard the pending instruction and target; the first fetch after release SHALL be from RESET_PC.
REQ-027 In the first cycle after reset release, the block SHALL drive oAddress=RESET_PC with oValid=0, and SHALL raise oValid one cycle later.

Structure
REQ-028 The opcode field positions, opcode values (NOP, STO, ADD, BLE, JMP, LED) and register codes SHALL remain in the shared definitions include; FSM state encodings SHALL be local to this block.
REQ-029 The PC SHALL be a sub-module, fetch_pc (load/increment/hold, ADDR_W wide, synchronous reset to RESET_PC); the IR, FSM and counter SHALL live in instruction_fetch.

Verification
REQ-030 Reset then iReady=1 held, ROM[n]=n+100: oValid rises at cycle 2, and oInstruction/oInstrPC sequence is 100/0, 101/1, 102/2 on consecutive cycles.
REQ-031 Stall: iReady=0 for 3 cycles while oInstrPC=5: oInstruction, oInstrPC=5 and oAddress=6 are all held; on release, oInstrPC=6 follows with no loss or duplication.
REQ-032 Redirect: iRedirect=1, target 8'd7 while PC=14: the next cycle has oValid=0 and oAddress=7, then oInstrPC=7 is valid; oFetchCount does not include the squashed slot.
REQ-033 Back-to-back redirects to 8'd2 then 8'd9: only a fetch from 9 appears; no instruction from 2 is ever valid.
REQ-034 Wrap and saturation: with PC preset near 16'hFFFF, oInstrPC goes FFFF then 0000; after 65536 transfers, oFetchCount stays at 16'hFFFF.
REQ-035 Reset asserted during a stall at oInstrPC=3: all outputs are 0 next cycle, and the first valid instruction after release has oInstrPC=RESET_PC.
